// File: rtl/branch_pkg.sv
// Shared types for the branch trace driver and the predictors it exercises.
package branch_pkg;

    typedef enum logic [1:0] {
        BTD_IDLE  = 2'd0,
        BTD_RUN   = 2'd1,
        BTD_DRAIN = 2'd2,
        BTD_DONE  = 2'd3
    } btd_state_t;

    localparam int BTD_PC_W = 32;

    typedef struct packed {
        logic                taken;
        logic [BTD_PC_W-1:0] pc;
    } trace_entry_t;

    // Two-bit saturating counter encodings used by the pshare/gshare predictors.
    localparam logic [1:0] CNT_SN = 2'b00;
    localparam logic [1:0] CNT_WN = 2'b01;
    localparam logic [1:0] CNT_WT = 2'b10;
    localparam logic [1:0] CNT_ST = 2'b11;

    function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
        return cnt[1];
    endfunction

endpackage

// File: rtl/btd_delay_line.sv
// Valid+payload shift register that carries each launched branch to the edge where
// its prediction is scored. flush_i drops everything in flight.
module btd_delay_line #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored branch trace into a predictor and scores the returned predictions.
// Optional last-miss reporting is enabled by defining BTD_LAST_MISS_EN.
module branch_trace_driver
    import branch_pkg::*;
#(
    parameter int Direction_SIZE = 32,
    parameter int TRACE_DEPTH    = 1024,
    parameter int PRED_LATENCY   = 2,
    parameter int CNT_W          = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            trace_wr_en,
    input  logic [$clog2(TRACE_DEPTH)-1:0]  trace_wr_addr,
    input  logic [Direction_SIZE:0]         trace_wr_data,
    input  logic [$clog2(TRACE_DEPTH):0]    trace_len,
    input  logic                            start,
    input  logic                            abort,
    output logic [Direction_SIZE-1:0]       direction,
    output logic                            branch_result,
    output logic                            br_valid,
    input  logic                            prediction,
    output logic                            busy,
    output logic                            done,
    output logic [CNT_W-1:0]                total_branch,
    output logic [CNT_W-1:0]                taken_count,
    output logic [CNT_W-1:0]                mispred_count,
    output logic [1:0]                      dbg_state
`ifdef BTD_LAST_MISS_EN
    ,
    output logic [Direction_SIZE-1:0]       last_miss_pc,
    output logic                            last_miss_valid
`endif
);

    localparam int AW  = $clog2(TRACE_DEPTH);
    localparam int LW  = AW + 1;
    localparam int DCW = (PRED_LATENCY > 1) ? $clog2(PRED_LATENCY) : 1;
`ifdef BTD_LAST_MISS_EN
    localparam int DLW = Direction_SIZE + 1;
`else
    localparam int DLW = 1;
`endif

    localparam logic [1:0] S_IDLE  = BTD_IDLE;
    localparam logic [1:0] S_RUN   = BTD_RUN;
    localparam logic [1:0] S_DRAIN = BTD_DRAIN;
    localparam logic [1:0] S_DONE  = BTD_DONE;

    logic [Direction_SIZE:0]   mem [TRACE_DEPTH];
    logic [1:0]                state_q, state_d;
    logic [AW-1:0]             idx_q;
    logic [LW-1:0]             len_q, len_clamped;
    logic [DCW-1:0]            drain_cnt_q;
    logic [Direction_SIZE-1:0] dir_q;
    logic                      taken_q, valid_q;
    logic [CNT_W-1:0]          total_q, taken_cnt_q, mispred_q;
    logic                      is_busy, start_ok, abort_ok, launch, last_launch;
    logic                      score, miss, dl_valid, dl_taken;
    logic [Direction_SIZE:0]   rd_entry;
    logic [DLW-1:0]            dl_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Writes are blocked while busy, so a launch never races a write to the same entry.
    always_ff @(posedge clk) begin
        if (trace_wr_en && !is_busy) mem[trace_wr_addr] <= trace_wr_data;
    end

    assign is_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_ok    = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign abort_ok    = abort && is_busy;
    assign launch      = (state_q == S_RUN) && !abort;
    assign last_launch = launch && ({1'b0, idx_q} == (len_q - LW'(1)));
    assign len_clamped = (trace_len > LW'(TRACE_DEPTH)) ? LW'(TRACE_DEPTH) : trace_len;
    assign rd_entry    = mem[idx_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = (trace_len == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort)            state_d = S_DONE;
                else if (last_launch) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                                    state_d = S_DONE;
                else if (drain_cnt_q == DCW'(PRED_LATENCY-1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            drain_cnt_q <= '0;
            dir_q       <= '0;
            taken_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= (state_q == S_DRAIN) ? drain_cnt_q + 1'b1 : '0;
            valid_q     <= launch;
            if (start_ok) begin
                idx_q <= '0;
                len_q <= len_clamped;
            end else if (launch) begin
                idx_q <= idx_q + 1'b1;
            end
            if (launch) begin
                dir_q   <= rd_entry[Direction_SIZE-1:0];
                taken_q <= rd_entry[Direction_SIZE];
            end
        end
    end

    btd_delay_line #(
        .DEPTH  (PRED_LATENCY),
        .DATA_W (DLW)
    ) u_delay (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (start_ok || abort_ok),
        .in_valid_i  (launch),
        .in_data_i   (rd_entry[Direction_SIZE -: DLW]),
        .out_valid_o (dl_valid),
        .out_data_o  (dl_out)
    );

    // An abort edge discards the entry that would otherwise be scored on it.
    assign dl_taken = dl_out[DLW-1];
    assign score    = dl_valid && !abort_ok;
    assign miss     = dl_taken != prediction;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
            mispred_q   <= '0;
        end else if (start_ok) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
            mispred_q   <= '0;
        end else if (score) begin
            total_q     <= sat_inc(total_q, 1'b1);
            taken_cnt_q <= sat_inc(taken_cnt_q, dl_taken);
            mispred_q   <= sat_inc(mispred_q, miss);
        end
    end

`ifdef BTD_LAST_MISS_EN
    logic [Direction_SIZE-1:0] lm_pc_q;
    logic                      lm_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lm_pc_q    <= '0;
            lm_valid_q <= 1'b0;
        end else if (start_ok) begin
            lm_pc_q    <= '0;
            lm_valid_q <= 1'b0;
        end else if (score && miss) begin
            lm_pc_q    <= dl_out[Direction_SIZE-1:0];
            lm_valid_q <= 1'b1;
        end
    end

    assign last_miss_pc    = lm_pc_q;
    assign last_miss_valid = lm_valid_q;
`endif

    assign direction     = dir_q;
    assign branch_result = taken_q;
    assign br_valid      = valid_q;
    assign busy          = is_busy;
    assign done          = (state_q == S_DONE);
    assign total_branch  = total_q;
    assign taken_count   = taken_cnt_q;
    assign mispred_count = mispred_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Self-checking bench for branch_trace_driver: directed scenarios plus randomized
// traces scored against a trace-level reference model.
module tb_branch_trace_driver;
  import branch_pkg::*;

  localparam int PCW   = 32;
  localparam int DEPTH = 32;
  localparam int LAT   = 3;
  localparam int CW    = 4;
  localparam int AW    = 5;
  localparam int LW    = 6;
  localparam int CMAX  = 15;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           trace_wr_en = 1'b0;
  logic [AW-1:0]  trace_wr_addr = '0;
  logic [PCW:0]   trace_wr_data = '0;
  logic [LW-1:0]  trace_len = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           prediction = 1'b0;
  logic [PCW-1:0] direction;
  logic           branch_result, br_valid, busy, done;
  logic [CW-1:0]  total_branch, taken_count, mispred_count;
  logic [1:0]     dbg_state;
`ifdef BTD_LAST_MISS_EN
  logic [PCW-1:0] last_miss_pc;
  logic           last_miss_valid;
`endif

  int checks = 0;
  int failures = 0;
  logic [PCW:0] exp_mem [DEPTH];
  logic         pred_seq [64];

  branch_trace_driver #(
    .Direction_SIZE (PCW),
    .TRACE_DEPTH    (DEPTH),
    .PRED_LATENCY   (LAT),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .trace_wr_en   (trace_wr_en),
    .trace_wr_addr (trace_wr_addr),
    .trace_wr_data (trace_wr_data),
    .trace_len     (trace_len),
    .start         (start),
    .abort         (abort),
    .direction     (direction),
    .branch_result (branch_result),
    .br_valid      (br_valid),
    .prediction    (prediction),
    .busy          (busy),
    .done          (done),
    .total_branch  (total_branch),
    .taken_count   (taken_count),
    .mispred_count (mispred_count),
    .dbg_state     (dbg_state)
`ifdef BTD_LAST_MISS_EN
    ,
    .last_miss_pc    (last_miss_pc),
    .last_miss_valid (last_miss_valid)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // driver tasks
  task automatic write_entry(input int addr, input logic [PCW:0] data);
    trace_wr_en   = 1'b1;
    trace_wr_addr = AW'(addr);
    trace_wr_data = data;
    tick();
    trace_wr_en   = 1'b0;
    exp_mem[addr] = data;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) write_entry(i, {1'($urandom_range(0, 1)), 32'($urandom)});
  endtask

  task automatic check_counts(input string tag, input int tot, input int tk, input int mis);
    check({tag, "_total"},   64'(total_branch),  64'(tot));
    check({tag, "_taken"},   64'(taken_count),   64'(tk));
    check({tag, "_mispred"}, 64'(mispred_count), 64'(mis));
  endtask

  // Full run: pmode 0 = prediction 0, 1 = prediction 1, 2 = random per cycle.
  task automatic run_trace(input string tag, input int len_req, input int pmode, input bit disturb);
    int len, tk, mis;
    logic [PCW-1:0] lpc;
    logic lv;
    len = (len_req > DEPTH) ? DEPTH : len_req;
    for (int c = 0; c < 64; c++)
      pred_seq[c] = (pmode == 2) ? 1'($urandom_range(0, 1)) : 1'(pmode);
    tk = 0; mis = 0; lpc = '0; lv = 1'b0;
    // entry k is launched at edge k+1 after start and scored at edge k+1+LAT
    for (int k = 0; k < len; k++) begin
      tk += int'(exp_mem[k][PCW]);
      if (pred_seq[k+1+LAT] != exp_mem[k][PCW]) begin
        mis++;
        lpc = exp_mem[k][PCW-1:0];
        lv  = 1'b1;
      end
    end
    start = 1'b1;
    trace_len = LW'(len_req);
    prediction = pred_seq[0];
    tick();
    start = 1'b0;
    if (len == 0) begin
      check({tag, "_done"}, 64'(done), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      for (int c = 0; c < 3; c++) begin
        check({tag, "_br_valid"}, 64'(br_valid), 64'(0));
        tick();
      end
      check_counts(tag, 0, 0, 0);
      return;
    end
    check({tag, "_busy0"}, 64'(busy), 64'(1));
    for (int c = 1; c <= len + LAT; c++) begin
      prediction = pred_seq[c];
      if (disturb && c == 2) begin
        trace_wr_en   = 1'b1;
        trace_wr_addr = AW'(len - 1);
        trace_wr_data = ~exp_mem[len-1];
        start         = 1'b1;
        trace_len     = LW'(1);
      end
      tick();
      trace_wr_en = 1'b0;
      start       = 1'b0;
      check({tag, "_br_valid"}, 64'(br_valid), 64'(c <= len));
      if (c <= len) begin
        check({tag, "_direction"}, 64'(direction), 64'(exp_mem[c-1][PCW-1:0]));
        check({tag, "_branch_result"}, 64'(branch_result), 64'(exp_mem[c-1][PCW]));
      end
      check({tag, "_busy"}, 64'(busy), 64'(c < len + LAT));
      check({tag, "_done"}, 64'(done), 64'(c >= len + LAT));
    end
    check({tag, "_dir_hold"}, 64'(direction), 64'(exp_mem[len-1][PCW-1:0]));
    check_counts(tag, sat(len), sat(tk), sat(mis));
`ifdef BTD_LAST_MISS_EN
    check({tag, "_last_miss_valid"}, 64'(last_miss_valid), 64'(lv));
    check({tag, "_last_miss_pc"}, 64'(last_miss_pc), 64'(lpc));
`else
    if (lv) lpc = '0;
`endif
  endtask

  // Abort sampled on edge a after start; prediction held at 0.
  task automatic run_abort(input string tag, input int len, input int a);
    int tot, tk;
    tot = 0; tk = 0;
    for (int k = 0; k < len; k++) begin
      if (k + 1 + LAT < a) begin
        tot++;
        tk += int'(exp_mem[k][PCW]);
      end
    end
    prediction = 1'b0;
    start = 1'b1;
    trace_len = LW'(len);
    tick();
    start = 1'b0;
    for (int c = 1; c < a; c++) begin
      tick();
      check({tag, "_br_valid"}, 64'(br_valid), 64'(1));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_br_valid_off"}, 64'(br_valid), 64'(0));
    check({tag, "_total_le3"}, 64'(total_branch <= CW'(3)), 64'(1));
    check_counts(tag, tot, tk, tk);
    tick();
    check({tag, "_total_stable"}, 64'(total_branch), 64'(tot));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_br_valid"}, 64'(br_valid), 64'(0));
    check({tag, "_direction"}, 64'(direction), 64'(0));
    check({tag, "_branch_result"}, 64'(branch_result), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(BTD_IDLE));
    check_counts(tag, 0, 0, 0);
`ifdef BTD_LAST_MISS_EN
    check({tag, "_last_miss_valid"}, 64'(last_miss_valid), 64'(0));
`endif
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    #3 reset = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    load_random(DEPTH);

    // zero-length run goes straight to DONE
    run_trace("len0", 0, 0, 1'b0);

    for (int i = 0; i < 4; i++) write_entry(i, {1'b1, 32'($urandom)});
    run_trace("all_taken", 4, 1, 1'b0);

    for (int i = 0; i < 4; i++) write_entry(i, {1'(i % 2 == 0), 32'($urandom)});
    run_trace("alt_taken", 4, 0, 1'b0);

    load_random(DEPTH);
    run_abort("abort3", 8, 3);
    run_abort("abort6", 8, 6);

    // reset while draining, then the same trace must replay
    prediction = 1'b1;
    start = 1'b1;
    trace_len = LW'(4);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check("mid_drain_busy", 64'(busy), 64'(1));
    check("mid_drain_scored", 64'(total_branch), 64'(2));
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    #2 reset = 1'b1;
    tick();
    run_trace("replay", 4, 2, 1'b0);

    for (int i = 0; i < 20; i++) write_entry(i, {1'b1, 32'($urandom)});
    run_trace("saturate", 20, 0, 1'b0);

    load_random(DEPTH);
    run_trace("clamp", 40, 2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      load_random(DEPTH);
      run_trace("random", $urandom_range(3, DEPTH), 2, r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
